// File: rtl/meas_pkg.sv
// Shared widths and types for the measurement front-end DAC path.
package meas_pkg;

  localparam int unsigned DAC_DATA_WIDTH = 24;
  localparam int unsigned DAC_CODE_WIDTH = 16;

  typedef logic [DAC_CODE_WIDTH-1:0] dac_code_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } dac_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr_i) + i) % N);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_spi_arbiter.sv
// Shares one DAC SPI master between NUM_REQ writers with last-value-wins slots
// and round-robin arbitration; acknowledges each finished frame per requester.
module dac_spi_arbiter
  import meas_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter logic [7:0]  DAC_CMD      = 8'h00,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ*DAC_CODE_WIDTH-1:0]   code_i,
  output logic [NUM_REQ-1:0]                  pend_o,
  output logic [NUM_REQ-1:0]                  done_o,
  output logic [DAC_DATA_WIDTH-1:0]           data_o,
  output logic                                wre_o,
  input  logic                                rdy_i,
  output logic                                err_o,
  output logic [NUM_REQ-1:0]                  ovw_o,
  input  logic                                clr_i
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  dac_arb_state_e              state_q, state_d;
  logic [PW-1:0]               ptr_q, ptr_d;
  logic [PW-1:0]               gnt_q, gnt_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  dac_code_t                   slot_q [NUM_REQ];
  dac_code_t                   slot_d [NUM_REQ];
  logic [NUM_REQ-1:0]          pend_q, pend_d;
  logic [NUM_REQ-1:0]          done_q, done_d;
  logic [NUM_REQ-1:0]          ovw_q, ovw_d;
  logic [DAC_DATA_WIDTH-1:0]   data_q, data_d;
  logic                        wre_q, wre_d;
  logic                        err_q, err_d;

  logic [NUM_REQ-1:0]          arb_oh;
  logic                        arb_valid;
  logic [PW-1:0]               arb_idx;
  logic                        grant;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i   (pend_q),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_oh),
    .valid_o (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (arb_oh[k]) arb_idx = PW'(k);
    end
  end

  // Next-state: frame sequencing first, then slot writes so a write on the
  // grant cycle re-arms the slot after the old code has been captured.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    pend_d  = pend_q;
    data_d  = data_q;
    done_d  = '0;
    wre_d   = 1'b0;
    err_d   = err_q & ~clr_i;
    ovw_d   = clr_i ? '0 : ovw_q;
    grant   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid && rdy_i) begin
          grant           = 1'b1;
          data_d          = {DAC_CMD, slot_q[arb_idx]};
          gnt_d           = arb_idx;
          ptr_d           = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + PW'(1);
          pend_d[arb_idx] = 1'b0;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        wre_d   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!rdy_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d         = 1'b1;
          done_d[gnt_q] = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (rdy_i) begin
          done_d[gnt_q] = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (req_i[k]) begin
        if (pend_q[k] && !(grant && (arb_idx == PW'(k)))) ovw_d[k] = 1'b1;
        slot_d[k] = code_i[k*DAC_CODE_WIDTH +: DAC_CODE_WIDTH];
        pend_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      done_q  <= '0;
      ovw_q   <= '0;
      data_q  <= '0;
      wre_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) slot_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      ovw_q   <= ovw_d;
      data_q  <= data_d;
      wre_q   <= wre_d;
      err_q   <= err_d;
      slot_q  <= slot_d;
    end
  end

  assign pend_o = pend_q;
  assign done_o = done_q;
  assign ovw_o  = ovw_q;
  assign data_o = data_q;
  assign wre_o  = wre_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Scenario tests plus a randomized run against a slot/round-robin reference model.
module tb_dac_spi_arbiter;

  localparam int unsigned NR = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NR-1:0] req_i;
  logic [31:0]   code_i;
  logic [NR-1:0] pend_o;
  logic [NR-1:0] done_o;
  logic [23:0]   data_o;
  logic          wre_o;
  logic          rdy_i;
  logic          err_o;
  logic [NR-1:0] ovw_o;
  logic          clr_i;

  int n_checks = 0;
  int n_fail   = 0;

  dac_spi_arbiter #(.NUM_REQ(NR), .DAC_CMD(8'h00), .BUSY_TIMEOUT(16)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .code_i (code_i),
    .pend_o (pend_o),
    .done_o (done_o),
    .data_o (data_o),
    .wre_o  (wre_o),
    .rdy_i  (rdy_i),
    .err_o  (err_o),
    .ovw_o  (ovw_o),
    .clr_i  (clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i  = '0;
    step();
    rst_ni = 1'b1;
  endtask

  // Bus-side SPI master stand-in: waits for the start strobe, stays busy, reports observations.
  task automatic serve(input int busy, output logic [23:0] dat, output logic [1:0] dn,
                       output logic [1:0] dn_next, output bit ok);
    ok = 1'b0; dat = '0; dn = '0; dn_next = '0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step();
      if (wre_o === 1'b1) begin ok = 1'b1; dat = data_o; end
    end
    if (!ok) return;
    ok = 1'b0;
    rdy_i = 1'b0;
    repeat (busy) step();
    rdy_i = 1'b1;
    for (int i = 0; i < 6 && !ok; i++) begin
      step();
      if (done_o !== 2'b00) begin ok = 1'b1; dn = done_o; end
    end
    step();
    dn_next = done_o;
  endtask

  task automatic test_reset();
    req_i = '0; code_i = '0; rdy_i = 1'b1; clr_i = 1'b0; rst_ni = 1'b0;
    step(); step();
    n_checks++; if (pend_o !== 2'b00) begin n_fail++; $display("FAIL reset_pend: got %b want 00", pend_o); end
    n_checks++; if (done_o !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", done_o); end
    n_checks++; if (data_o !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", data_o); end
    n_checks++; if (wre_o !== 1'b0) begin n_fail++; $display("FAIL reset_wre: got %b want 0", wre_o); end
    n_checks++; if (err_o !== 1'b0 || ovw_o !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got err=%b ovw=%b want 0/00", err_o, ovw_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    int nd;
    code_i = {16'h0000, 16'h1234}; req_i = 2'b01;
    step();
    req_i = '0;
    n_checks++; if (pend_o !== 2'b01) begin n_fail++; $display("FAIL single_pend_set: got %b want 01", pend_o); end
    step();
    n_checks++; if (wre_o !== 1'b0) begin n_fail++; $display("FAIL single_wre_early: got %b want 0", wre_o); end
    n_checks++; if (pend_o !== 2'b00) begin n_fail++; $display("FAIL single_pend_clr: got %b want 00", pend_o); end
    step();
    n_checks++; if (wre_o !== 1'b1) begin n_fail++; $display("FAIL single_wre_edge3: got %b want 1", wre_o); end
    n_checks++; if (data_o !== 24'h001234) begin n_fail++; $display("FAIL single_data: got %h want 001234", data_o); end
    rdy_i = 1'b0;
    step();
    n_checks++; if (wre_o !== 1'b0) begin n_fail++; $display("FAIL single_wre_width: got %b want 0", wre_o); end
    nd = (done_o !== 2'b00) ? 1 : 0;
    repeat (19) begin step(); if (done_o !== 2'b00) nd++; end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL single_done_early: got %0d pulses want 0", nd); end
    rdy_i = 1'b1;
    step();
    n_checks++; if (done_o !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b want 01", done_o); end
    step();
    n_checks++; if (done_o !== 2'b00) begin n_fail++; $display("FAIL single_done_width: got %b want 00", done_o); end
    n_checks++; if (pend_o !== 2'b00) begin n_fail++; $display("FAIL single_pend_after: got %b want 00", pend_o); end
  endtask

  task automatic test_simultaneous();
    logic [23:0] dat; logic [1:0] dn, dn2; bit ok;
    logic [23:0] exp_d [4];
    logic [1:0]  exp_n [4];
    exp_d[0] = 24'h00AAAA; exp_n[0] = 2'b01;
    exp_d[1] = 24'h005555; exp_n[1] = 2'b10;
    exp_d[2] = 24'h005555; exp_n[2] = 2'b10;
    exp_d[3] = 24'h00AAAA; exp_n[3] = 2'b01;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        code_i = {16'h0000, 16'h0F0F}; req_i = 2'b01;
        step(); req_i = '0;
        serve(2, dat, dn, dn2, ok);
        n_checks++; if (!ok || dat !== 24'h000F0F) begin n_fail++; $display("FAIL simul_ptr_setup: got ok=%0d data=%h want 1/000F0F", ok, dat); end
      end
      code_i = {16'h5555, 16'hAAAA}; req_i = 2'b11;
      step(); req_i = '0;
      for (int f = 0; f < 2; f++) begin
        serve(3 + f, dat, dn, dn2, ok);
        n_checks++; if (!ok || dat !== exp_d[pass*2+f]) begin n_fail++; $display("FAIL simul_data p%0d f%0d: got ok=%0d data=%h want %h", pass, f, ok, dat, exp_d[pass*2+f]); end
        n_checks++; if (dn !== exp_n[pass*2+f] || dn2 !== 2'b00) begin n_fail++; $display("FAIL simul_done p%0d f%0d: got %b then %b want %b then 00", pass, f, dn, dn2, exp_n[pass*2+f]); end
      end
    end
  endtask

  task automatic test_overwrite();
    logic [23:0] dat; logic [1:0] dn, dn2; bit ok, seen; logic [1:0] dv;
    code_i = {16'h0000, 16'h1111}; req_i = 2'b01;
    step(); req_i = '0;
    step(); step();
    n_checks++; if (wre_o !== 1'b1 || data_o !== 24'h001111) begin n_fail++; $display("FAIL ovw_first: got wre=%b data=%h want 1/001111", wre_o, data_o); end
    rdy_i = 1'b0;
    code_i = {16'h0001, 16'h0000}; req_i = 2'b10; step();
    code_i = {16'h0002, 16'h0000}; step();
    req_i = '0;
    n_checks++; if (ovw_o !== 2'b10 || pend_o !== 2'b10) begin n_fail++; $display("FAIL ovw_flag: got ovw=%b pend=%b want 10/10", ovw_o, pend_o); end
    repeat (3) step();
    rdy_i = 1'b1; seen = 1'b0; dv = '0;
    for (int i = 0; i < 5 && !seen; i++) begin step(); if (done_o !== 2'b00) begin seen = 1'b1; dv = done_o; end end
    n_checks++; if (dv !== 2'b01) begin n_fail++; $display("FAIL ovw_done0: got %b want 01", dv); end
    serve(2, dat, dn, dn2, ok);
    n_checks++; if (!ok || dat !== 24'h000002 || dn !== 2'b10) begin n_fail++; $display("FAIL ovw_second: got ok=%0d data=%h done=%b want 1/000002/10", ok, dat, dn); end
    n_checks++; if (ovw_o !== 2'b10) begin n_fail++; $display("FAIL ovw_sticky: got %b want 10", ovw_o); end
    clr_i = 1'b1; step(); clr_i = 1'b0;
    n_checks++; if (ovw_o !== 2'b00) begin n_fail++; $display("FAIL ovw_clear: got %b want 00", ovw_o); end
  endtask

  task automatic test_rewrite_on_grant();
    logic [23:0] dat; logic [1:0] dn, dn2; bit ok;
    code_i = {16'h0000, 16'hA0A0}; req_i = 2'b01; step();
    code_i = {16'h0000, 16'hBEEF}; step();
    req_i = '0;
    n_checks++; if (data_o !== 24'h00A0A0 || pend_o !== 2'b01 || ovw_o !== 2'b00) begin n_fail++; $display("FAIL rewrite_grant: got data=%h pend=%b ovw=%b want 00A0A0/01/00", data_o, pend_o, ovw_o); end
    serve(2, dat, dn, dn2, ok);
    n_checks++; if (!ok || dat !== 24'h00A0A0 || dn !== 2'b01) begin n_fail++; $display("FAIL rewrite_old: got ok=%0d data=%h done=%b want 1/00A0A0/01", ok, dat, dn); end
    serve(2, dat, dn, dn2, ok);
    n_checks++; if (!ok || dat !== 24'h00BEEF || dn !== 2'b01) begin n_fail++; $display("FAIL rewrite_new: got ok=%0d data=%h done=%b want 1/00BEEF/01", ok, dat, dn); end
    n_checks++; if (ovw_o !== 2'b00 || pend_o !== 2'b00) begin n_fail++; $display("FAIL rewrite_flags: got ovw=%b pend=%b want 00/00", ovw_o, pend_o); end
  endtask

  task automatic test_timeout();
    logic [23:0] dat; logic [1:0] dn, dn2; bit ok, seen; int lat; logic [1:0] dv;
    code_i = {16'h7777, 16'h0000}; req_i = 2'b10; step(); req_i = '0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin step(); if (wre_o === 1'b1) seen = 1'b1; end
    n_checks++; if (!seen || data_o !== 24'h007777) begin n_fail++; $display("FAIL timeout_start: got seen=%0d data=%h want 1/007777", seen, data_o); end
    code_i = {16'h0000, 16'h3333}; req_i = 2'b01;
    seen = 1'b0; lat = 0; dv = '0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(); req_i = '0; lat++;
      if (done_o !== 2'b00) begin seen = 1'b1; dv = done_o; end
    end
    n_checks++; if (!seen || lat !== 16) begin n_fail++; $display("FAIL timeout_latency: got seen=%0d cycles=%0d want 1/16", seen, lat); end
    n_checks++; if (dv !== 2'b10 || err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_done_err: got done=%b err=%b want 10/1", dv, err_o); end
    serve(3, dat, dn, dn2, ok);
    n_checks++; if (!ok || dat !== 24'h003333 || dn !== 2'b01) begin n_fail++; $display("FAIL timeout_next: got ok=%0d data=%h done=%b want 1/003333/01", ok, dat, dn); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", err_o); end
    clr_i = 1'b1; step(); clr_i = 1'b0;
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b want 0", err_o); end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] dat; logic [1:0] dn, dn2; bit ok; int bad;
    code_i = {16'h0000, 16'h5A5A}; req_i = 2'b01; step(); req_i = '0;
    step(); step();
    rdy_i = 1'b0;
    code_i = {16'h1357, 16'h0000}; req_i = 2'b10; step(); req_i = '0;
    step();
    rst_ni = 1'b0; step(); rst_ni = 1'b1;
    n_checks++; if (pend_o !== 2'b00 || done_o !== 2'b00 || wre_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got pend=%b done=%b wre=%b want 00/00/0", pend_o, done_o, wre_o); end
    n_checks++; if (data_o !== 24'h0 || err_o !== 1'b0 || ovw_o !== 2'b00) begin n_fail++; $display("FAIL midrst_data: got data=%h err=%b ovw=%b want 000000/0/00", data_o, err_o, ovw_o); end
    code_i = {16'h2468, 16'h0000}; req_i = 2'b10; step(); req_i = '0;
    bad = 0;
    repeat (10) begin step(); if (wre_o !== 1'b0 || done_o !== 2'b00) bad++; end
    n_checks++; if (bad !== 0 || pend_o !== 2'b10) begin n_fail++; $display("FAIL midrst_hold: got bad=%0d pend=%b want 0/10", bad, pend_o); end
    rdy_i = 1'b1;
    serve(2, dat, dn, dn2, ok);
    n_checks++; if (!ok || dat !== 24'h002468 || dn !== 2'b10) begin n_fail++; $display("FAIL midrst_resume: got ok=%0d data=%h done=%b want 1/002468/10", ok, dat, dn); end
  endtask

  function automatic int pick(input bit [1:0] p, input int ptr);
    for (int i = 0; i < 2; i++) if (p[(ptr + i) % 2]) return (ptr + i) % 2;
    return -1;
  endfunction

  task automatic test_random();
    bit [1:0] m_pend, m_ovw, s_req, o_pend, o_ovw, cur_req;
    logic [15:0] m_code [2];
    logic [15:0] s_code [2];
    logic [15:0] cur_code [2];
    int m_ptr, exp_gnt, w, busy_cnt;
    int m_frames [2];
    int d_frames [2];
    bit s_valid, m_err, granted, active;
    m_pend = '0; m_ovw = '0; s_req = '0; o_pend = '0; o_ovw = '0;
    m_ptr = 0; exp_gnt = 0; busy_cnt = 0; s_valid = 1'b0; m_err = 1'b0;
    for (int k = 0; k < 2; k++) begin m_code[k] = '0; s_code[k] = '0; m_frames[k] = 0; d_frames[k] = 0; end
    rdy_i = 1'b1; clr_i = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 420; cyc++) begin
      active = (cyc < 300);
      rdy_i = (busy_cnt == 0);
      if (busy_cnt > 0) busy_cnt--;
      for (int k = 0; k < 2; k++) begin
        cur_req[k]  = active && ($urandom_range(0, 9) < 3);
        cur_code[k] = 16'($urandom);
      end
      req_i = cur_req; code_i = {cur_code[1], cur_code[0]};
      step();
      granted = (wre_o === 1'b1); w = -1;
      if (granted) begin
        w = pick(m_pend, m_ptr);
        n_checks++;
        if (w < 0) begin
          n_fail++; $display("FAIL rand_spurious_frame cyc %0d: got data=%h want no frame", cyc, data_o);
        end else begin
          if (data_o !== {8'h00, m_code[w]}) begin n_fail++; $display("FAIL rand_data cyc %0d: got %h want %h", cyc, data_o, {8'h00, m_code[w]}); end
          m_pend[w] = 1'b0; m_ptr = (w + 1) % 2; exp_gnt = w; m_frames[w]++;
        end
        if ($urandom_range(0, 7) == 0) begin busy_cnt = 0; m_err = 1'b1; end
        else busy_cnt = $urandom_range(1, 6);
      end
      if (s_valid) begin
        for (int k = 0; k < 2; k++) begin
          if (s_req[k]) begin
            if (m_pend[k] && !(granted && w == k)) m_ovw[k] = 1'b1;
            m_code[k] = s_code[k]; m_pend[k] = 1'b1;
          end
        end
        n_checks++; if (o_pend !== m_pend) begin n_fail++; $display("FAIL rand_pend cyc %0d: got %b want %b", cyc, o_pend, m_pend); end
        n_checks++; if (o_ovw !== m_ovw) begin n_fail++; $display("FAIL rand_ovw cyc %0d: got %b want %b", cyc, o_ovw, m_ovw); end
      end
      s_req = cur_req; s_code = cur_code; s_valid = 1'b1; o_pend = pend_o; o_ovw = ovw_o;
      if (done_o !== 2'b00) begin
        n_checks++; if (done_o !== (2'b01 << exp_gnt)) begin n_fail++; $display("FAIL rand_done cyc %0d: got %b want %b", cyc, done_o, 2'b01 << exp_gnt); end
        if (done_o == 2'b01) d_frames[0]++;
        if (done_o == 2'b10) d_frames[1]++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d_frames[k] !== m_frames[k]) begin n_fail++; $display("FAIL rand_frames req%0d: got %0d dones want %0d", k, d_frames[k], m_frames[k]); end
    end
    n_checks++; if (pend_o !== 2'b00 || err_o !== m_err) begin n_fail++; $display("FAIL rand_final: got pend=%b err=%b want 00/%b", pend_o, err_o, m_err); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overwrite();
    test_rewrite_on_grant();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
